// File: rtl/binary2bcd_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The controller uses the master view; the converter uses the slave view.
interface binary2bcd_if #(
    parameter int unsigned N = 16,
    parameter int unsigned D = 5
);
    logic             start;
    logic [N-1:0]     number;
    logic             busy;
    logic             done;
    logic [4*D-1:0]   bcd;
    logic             overflow;
    logic             sign;

    modport master (
        output start, number,
        input  busy, done, bcd, overflow, sign
    );

    modport slave (
        input  start, number,
        output busy, done, bcd, overflow, sign
    );
endinterface

// File: rtl/binary2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Define BINARY2BCD_SIGNED_EN to treat number as two's complement (magnitude + sign).
module binary2bcd_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned D = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    binary2bcd_if.slave    bus
);
    localparam int unsigned BW = 4 * D;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          r_state;
    logic [N-1:0]    r_shift;
    logic [BW-1:0]   r_scratch;
    logic            r_ovf_scr;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_next;
    logic            w_carry;
    logic            w_last;
    logic [N-1:0]    w_mag;

    // Add-3 correction on every scratch digit that would overflow when doubled
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned i = 0; i < D; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_next  = {w_adj[BW-2:0], r_shift[N-1]};
    assign w_carry = w_adj[BW-1];
    assign w_last  = (r_cnt == CW'(N - 1));

`ifdef BINARY2BCD_SIGNED_EN
    logic r_neg;
    logic r_sign;

    // Magnitude of the most negative value wraps to 2^(N-1), which is correct unsigned
    assign w_mag    = bus.number[N-1] ? (N'(0) - bus.number) : bus.number;
    assign bus.sign = r_sign;
`else
    assign w_mag    = bus.number;
    assign bus.sign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_ovf_scr <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
`ifdef BINARY2BCD_SIGNED_EN
            r_neg     <= 1'b0;
            r_sign    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift   <= w_mag;
                        r_scratch <= '0;
                        r_ovf_scr <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
`ifdef BINARY2BCD_SIGNED_EN
                        r_neg     <= bus.number[N-1];
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next;
                    r_shift   <= {r_shift[N-2:0], 1'b0};
                    r_ovf_scr <= r_ovf_scr | w_carry;
                    r_cnt     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bcd   <= w_next;
                        r_ovf   <= r_ovf_scr | w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef BINARY2BCD_SIGNED_EN
                        r_sign  <= r_neg;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_binary2bcd_seq.sv
// Directed bench for binary2bcd_seq: a 5-digit and a 4-digit instance driven in lockstep.
module tb_binary2bcd_seq;
    localparam int unsigned N = 16;

    typedef struct {
        logic [15:0] num;
        logic [19:0] bcd5;
        logic [15:0] bcd4;
        logic        ovf4;
        logic        sgn;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    binary2bcd_if #(.N(16), .D(5)) m5 ();
    binary2bcd_if #(.N(16), .D(4)) m4 ();

    binary2bcd_seq #(.N(16), .D(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(m5));
    binary2bcd_seq #(.N(16), .D(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: low nd digits of v, independent of the shift-add method
    function automatic logic [31:0] ref_bcd(input int v, input int nd);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < nd; k++) begin
            r = r | (32'(t % 10) << (4 * k));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic drive(input logic s, input logic [15:0] num);
        m5.start  = s;
        m5.number = num;
        m4.start  = s;
        m4.number = num;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!m5.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One conversion from IDLE; returns latency, busy cycles and busy/done overlap
    task automatic convert(input logic [15:0] num, output int lat, output int bc, output bit ovl);
        @(negedge clk);
        drive(1'b1, num);
        @(posedge clk);
        #1;
        drive(1'b0, 16'(~num));
        lat = 0;
        bc  = 0;
        ovl = 1'b0;
        if (m5.busy) bc++;
        while (!m5.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (m5.busy) bc++;
            if (m5.busy && m5.done) ovl = 1'b1;
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   lat;
        int   bc;
        bit   ovl;
        int   nd;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 16'h0000);

        vecs.push_back('{16'd0,     20'h00000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'd101,   20'h00101, 16'h0101, 1'b0, 1'b0});
        vecs.push_back('{16'd9999,  20'h09999, 16'h9999, 1'b0, 1'b0});
        vecs.push_back('{16'd12345, 20'h12345, 16'h2345, 1'b1, 1'b0});
        vecs.push_back('{16'd500,   20'h00500, 16'h0500, 1'b0, 1'b0});
        vecs.push_back('{16'd300,   20'h00300, 16'h0300, 1'b0, 1'b0});
`ifdef BINARY2BCD_SIGNED_EN
        vecs.push_back('{16'h8000,  20'h32768, 16'h2768, 1'b1, 1'b1});
        vecs.push_back('{16'hFFFF,  20'h00001, 16'h0001, 1'b0, 1'b1});
`else
        vecs.push_back('{16'h8000,  20'h32768, 16'h2768, 1'b1, 1'b0});
        vecs.push_back('{16'd65535, 20'h65535, 16'h5535, 1'b1, 1'b0});
`endif
        for (int i = 1; i <= 100; i++) begin
            v.num  = 16'(i);
            v.bcd5 = 20'(ref_bcd(i, 5));
            v.bcd4 = 16'(ref_bcd(i, 4));
            v.ovf4 = 1'b0;
            v.sgn  = 1'b0;
            vecs.push_back(v);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(m5.busy), 32'd0);
        check("reset_done", 32'(m5.done), 32'd0);
        check("reset_bcd",  32'(m5.bcd),  32'd0);
        check("reset_ovf",  32'(m5.overflow), 32'd0);
        check("reset_sign", 32'(m5.sign), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            convert(vecs[i].num, lat, bc, ovl);
            check($sformatf("latency[%0d]", vecs[i].num), 32'(lat), 32'(N));
            check($sformatf("busy_cycles[%0d]", vecs[i].num), 32'(bc), 32'(N));
            check($sformatf("busy_done_overlap[%0d]", vecs[i].num), 32'(ovl), 32'd0);
            check($sformatf("bcd5[%0d]", vecs[i].num), 32'(m5.bcd), 32'(vecs[i].bcd5));
            check($sformatf("ovf5[%0d]", vecs[i].num), 32'(m5.overflow), 32'd0);
            check($sformatf("sign[%0d]", vecs[i].num), 32'(m5.sign), 32'(vecs[i].sgn));
            check($sformatf("bcd4[%0d]", vecs[i].num), 32'(m4.bcd), 32'(vecs[i].bcd4));
            check($sformatf("ovf4[%0d]", vecs[i].num), 32'(m4.overflow), 32'(vecs[i].ovf4));
            @(posedge clk);
            #1;
            check($sformatf("done_one_cycle[%0d]", vecs[i].num), 32'(m5.done), 32'd0);
            check($sformatf("bcd_hold[%0d]", vecs[i].num), 32'(m5.bcd), 32'(vecs[i].bcd5));
        end

        // Start during SHIFT is ignored
        @(negedge clk);
        drive(1'b1, 16'd500);
        @(posedge clk);
        #1;
        drive(1'b0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        drive(1'b1, 16'd7);
        repeat (3) @(posedge clk);
        #1;
        drive(1'b0, 16'd7);
        wait_done(6, lat);
        check("midshift_latency", 32'(lat), 32'(N));
        check("midshift_bcd", 32'(m5.bcd), 32'h00500);

        // Start in the DONE cycle is accepted immediately
        drive(1'b1, 16'd42);
        @(posedge clk);
        #1;
        drive(1'b0, 16'd999);
        check("donestart_done_low", 32'(m5.done), 32'd0);
        check("donestart_busy_high", 32'(m5.busy), 32'd1);
        wait_done(0, lat);
        check("donestart_latency", 32'(lat), 32'(N));
        check("donestart_bcd", 32'(m5.bcd), 32'h00042);
        check("donestart_bcd4", 32'(m4.bcd), 32'h0042);

        // Reset at step 8 abandons the conversion
        @(negedge clk);
        drive(1'b1, 16'd1234);
        @(posedge clk);
        #1;
        drive(1'b0, 16'd0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(m5.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset_busy", 32'(m5.busy), 32'd0);
        check("midreset_done", 32'(m5.done), 32'd0);
        check("midreset_bcd",  32'(m5.bcd),  32'd0);
        check("midreset_ovf",  32'(m4.overflow), 32'd0);
        nd = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (m5.done || m5.busy) nd++;
        end
        check("midreset_no_done", 32'(nd), 32'd0);
        convert(16'd77, lat, bc, ovl);
        check("after_reset_latency", 32'(lat), 32'(N));
        check("after_reset_bcd", 32'(m5.bcd), 32'h00077);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
